// File: rtl/uart_rx.sv
// 8N1 UART receiver with a small receive FIFO and a two-register CPU byte interface.
// RX is synchronised, deframed by a mid-bit sampling FSM and buffered until the CPU reads it.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 26,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       addr,
  input  logic       rd,
  input  logic       wr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       rx_ready
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = AW + 1;
  localparam logic [CW-1:0] CPB_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [NW-1:0] DEPTH_N = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            sync1_q, sync2_q;
  logic            rx_s;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [NW-1:0]   count_q, count_d;
  logic            ovr_q, ovr_d;
  logic            fe_q, fe_d;

  logic stop_smp_s, frame_ok_s, frame_err_s;
  logic empty_s, full_s, pop_s, push_s;
  logic ovr_set_s, ovr_clr_s, fe_clr_s;
  logic unused_s;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          bit_q <= 3'd0;
          if (!rx_s) state_q <= S_START;
        end
        S_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            state_q <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == CPB_M1) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == CPB_M1) begin
            cnt_q   <= '0;
            state_q <= rx_s ? S_IDLE : S_WAIT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WAIT: begin
          if (rx_s) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The push/flag decision is taken on the same edge as the mid-stop sample.
  assign stop_smp_s  = (state_q == S_STOP) && (cnt_q == CPB_M1);
  assign frame_ok_s  = stop_smp_s & rx_s;
  assign frame_err_s = stop_smp_s & ~rx_s;

  assign empty_s   = (count_q == '0);
  assign full_s    = (count_q == DEPTH_N);
  assign pop_s     = rd & ~addr & ~empty_s;
  assign push_s    = frame_ok_s & (~full_s | pop_s);
  assign ovr_set_s = frame_ok_s & full_s & ~pop_s;
  assign ovr_clr_s = wr & addr & wdata[3];
  assign fe_clr_s  = wr & addr & wdata[2];
  assign unused_s  = ^{wdata[7:4], wdata[1:0]};

  always_comb begin
    wptr_d  = push_s ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop_s  ? rptr_q + AW'(1) : rptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + NW'(1);
      2'b01:   count_d = count_q - NW'(1);
      default: count_d = count_q;
    endcase
    ovr_d = ovr_set_s   | (ovr_q & ~ovr_clr_s);
    fe_d  = frame_err_s | (fe_q  & ~fe_clr_s);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) mem_q[wptr_q] <= shift_q;
  end

  always_comb begin
    if (addr) begin
      rdata = {4'b0000, ovr_q, fe_q, full_s, ~empty_s};
    end else if (empty_s) begin
      rdata = 8'h00;
    end else begin
      rdata = mem_q[rptr_q];
    end
  end

  assign rx_ready = ~empty_s;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit-by-bit, a queue model predicts the
// FIFO contents and sticky flags, and a negedge monitor checks every DATA read.
module tb_uart_rx;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;

  logic       clk, reset_n, rx, addr, rd, wr;
  logic [7:0] wdata, rdata;
  logic       rx_ready;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic       m_ovr = 1'b0;
  logic       m_fe  = 1'b0;
  int         cyc;

  uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .addr(addr), .rd(rd), .wr(wr),
    .wdata(wdata), .rdata(rdata), .rx_ready(rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_status();
    return {4'b0000, m_ovr, m_fe, exp_q.size() == DEPTH, exp_q.size() != 0};
  endfunction

  // Monitor: every DATA read strobe is compared against the head of the model FIFO.
  always @(negedge clk) begin
    if (reset_n && rd && !addr) begin
      if (exp_q.size() > 0) check("data_read", rdata, exp_q.pop_front());
      else                  check("data_read_empty", rdata, 8'h00);
    end
  end

  // Raw waveform of one 8N1 character; callers start just after a posedge.
  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stop_b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_char(input logic [7:0] b);
    send_frame(b, 1'b1);
    if (exp_q.size() < DEPTH) exp_q.push_back(b);
    else                      m_ovr = 1'b1;
  endtask

  task automatic do_read();
    @(posedge clk); #1;
    addr = 1'b0; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] d);
    @(posedge clk); #1;
    addr = 1'b1; wr = 1'b1; wdata = d;
    @(posedge clk); #1;
    wr = 1'b0; addr = 1'b0; wdata = 8'h00;
    if (d[3]) m_ovr = 1'b0;
    if (d[2]) m_fe  = 1'b0;
  endtask

  task automatic check_status(input string name);
    addr = 1'b1; #1;
    check({name, "_status"}, rdata, model_status());
    check({name, "_rx_ready"}, rx_ready, exp_q.size() != 0);
    addr = 1'b0; #1;
    check({name, "_data_peek"}, rdata, (exp_q.size() != 0) ? exp_q[0] : 8'h00);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; rx = 1'b1; addr = 1'b0; rd = 1'b0; wr = 1'b0; wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_status("in_reset");
    reset_n = 1'b1;
    idle(4);
    check_status("after_reset");

    // Basic receive with latency measurement from the start-bit falling edge.
    fork
      send_char(8'hA5);
      begin
        cyc = 0;
        while (!rx_ready && cyc < 200) begin
          @(posedge clk); #1; cyc++;
        end
      end
    join
    n_tests++;
    if (cyc < 78 || cyc > 80) begin
      n_fail++;
      $display("FAIL ready_latency: got %0d clocks, expected 78..80", cyc);
    end
    check_status("basic_pre");
    do_read();
    check_status("basic_post");

    // Glitch shorter than half a bit must not start a character.
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    idle(24);
    check_status("glitch");

    // Overrun: fifth byte dropped.
    for (int i = 1; i <= 5; i++) send_char(8'(i));
    check_status("overrun");
    addr = 1'b1; #1;
    check("overrun_status_0B", rdata, 8'h0B);
    addr = 1'b0;
    for (int i = 0; i < 4; i++) do_read();
    check_status("overrun_drained");
    do_write(8'h08);
    check_status("overrun_cleared");

    // Framing error followed by a long break, then a good character.
    send_frame(8'h55, 1'b0);
    m_fe = 1'b1;
    repeat (40 * CPB) @(posedge clk);
    #1;
    idle(2 * CPB);
    check_status("break");
    addr = 1'b1; #1;
    check("break_status_04", rdata, 8'h04);
    addr = 1'b0;
    send_char(8'h3C);
    check_status("after_break");
    do_read();
    do_write(8'h04);
    check_status("fe_cleared");

    // Full FIFO with a pop on the exact push edge of the fifth byte.
    for (int i = 0; i < 4; i++) send_char(8'h10 + 8'(i));
    fork
      send_char(8'h14);
      begin
        repeat (78) @(posedge clk);
        #1; addr = 1'b0; rd = 1'b1;
        @(posedge clk);
        #1; rd = 1'b0;
      end
    join
    check_status("full_pop");
    for (int i = 0; i < 4; i++) do_read();
    check_status("full_pop_drained");

    // Randomised traffic: good and bad frames, gaps, reads and flag clears.
    for (int n = 0; n < 30; n++) begin
      logic [7:0] b;
      b = 8'($urandom);
      idle($urandom_range(4, 20));
      if ($urandom_range(0, 7) == 0) begin
        send_frame(b, 1'b0);
        m_fe = 1'b1;
        idle(3);
      end else begin
        send_char(b);
      end
      check_status("rand");
      if ($urandom_range(0, 3) == 0) do_write(8'h0C);
      for (int r = $urandom_range(0, 2); r > 0; r--) do_read();
    end
    while (exp_q.size() > 0) do_read();
    do_write(8'h0C);
    check_status("rand_end");

    // Reset during data bit 4 of 0xFF, with a byte already buffered.
    send_char(8'h77);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (43) @(posedge clk);
        #1; reset_n = 1'b0;
        @(posedge clk);
        #1; reset_n = 1'b1;
        exp_q.delete();
        m_ovr = 1'b0;
        m_fe  = 1'b0;
      end
    join
    idle(CPB);
    check_status("mid_reset");
    send_char(8'h12);
    check_status("post_reset_rx");
    do_read();
    check_status("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Hardware UART receiver peripheral for the f8 system, the receive-side counterpart to the serial TX line driven by the system. It samples the asynchronous RX pin in the 3 MHz system clock domain, deframes 8N1 characters, and buffers them in a small FIFO. The CPU reads the FIFO and status through a two-register byte interface. `rx_ready` is available as an interrupt or poll source.

## Interface
- `CLKS_PER_BIT`, 26, system clocks per bit (3 MHz / 115200 ≈ 26); legal range 4..65535
- `FIFO_DEPTH`, 4, receive FIFO entries; power of two, 2..16

Ports:
- `clk` in 1: system clock; all logic on posedge
- `reset_n` in 1: synchronous, active-low reset
- `rx` in 1: asynchronous serial input, idle high
- `addr` in 1: 0 = DATA register, 1 = STATUS register
- `rd` in 1: read strobe, one cycle
- `wr` in 1: write strobe, one cycle
- `wdata` in 8: write data (STATUS only)
- `rdata` out 8: combinational read data for the current `addr`
- `rx_ready` out 1: FIFO not empty

## Operation
- Input path: 2-flop synchronizer feeds `rx_s`. All decisions use `rx_s`.
- FSM states and transitions:
  - IDLE: go to START when `rx_s` = 0; bit counter cleared.
  - START: count `CLKS_PER_BIT/2` clocks (integer floor) to mid-start, then sample. If 1, treat as a glitch and return to IDLE. If 0, go to DATA.
  - DATA: sample every `CLKS_PER_BIT` clocks. 8 bits, LSB first, shifted into the shift register. After bit 7, go to STOP.
  - STOP: sample after `CLKS_PER_BIT` clocks.
    - If 1: push the byte. If the FIFO is full (with no simultaneous pop), drop the byte and set OVR. Go to IDLE.
    - If 0: set FE, drop the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s` = 1, then go to IDLE. Break conditions therefore produce exactly one FE.
- Register map:
  - DATA read returns the FIFO head. A `rd` with `addr` = 0 pops one entry. If the FIFO is empty, `rdata` = 0x00 and there is no effect.
  - STATUS read returns {4'b0, OVR, FE, full, !empty}. It has no side effect.
  - STATUS write is write-1-to-clear: bit 3 clears OVR, bit 2 clears FE. Other bits are ignored. Writes to DATA are ignored.
  - If a set and a clear of the same sticky bit happen in the same cycle, set wins.
- FIFO uses wrap-around read/write pointers plus a count.
  - Simultaneous push and pop when full: both happen, count unchanged, no OVR.
  - Simultaneous push and pop when empty: push only.
- Bit counter width is `$clog2(CLKS_PER_BIT)` + 1. There is no overflow at the maximum parameter value.

## Timing
- Reset values: FSM = IDLE, FIFO empty, OVR = FE = 0, synchronizer flops = 1, `rx_ready` = 0, `rdata` = 0x00 (both addresses).
- Reset asserted mid-character aborts the character with no push and no flag. After release, the FSM starts from IDLE and needs `rx_s` = 0 to begin.
- Falling edge on `rx` to entering START: 3 clocks (2 synchronizer stages plus 1).
- The byte is pushed on the clock edge at which the mid-stop sample is taken. `rx_ready` and the new `rdata` are visible the cycle after that edge.
- From `rx` falling edge to push: 3 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` clocks, ±1.
- Pop takes effect on the `rd` edge. The next head appears on `rdata` the following cycle.
- Back-to-back characters: the next start bit may begin immediately after the stop-bit midpoint. IDLE is re-entered in time to catch it.

## Test plan
- Basic receive, `CLKS_PER_BIT` = 8: send 0xA5 in 8N1.
  - `rx_ready` rises at 3+4+72 ±1 clocks.
  - DATA read gives 0xA5.
  - Pop clears `rx_ready`. STATUS = 0x00.
- Glitch rejection: drive `rx` low for 2 clocks while idle, then high. No push, FSM back in IDLE, STATUS = 0x00.
- Overrun with `FIFO_DEPTH` = 4:
  - Send 0x01..0x05 without reading. STATUS = 0x0B (full, OVR, not empty).
  - Reads return 0x01..0x04, then `rx_ready` = 0.
  - Write 0x08 to STATUS: OVR clears.
- Framing/break: send 0x55 with stop bit = 0, then hold `rx` low for 40 bit times, then release.
  - Exactly one FE, no push, STATUS = 0x04.
  - Next valid 0x3C is received correctly.
- Full with simultaneous pop: fill the FIFO, then issue a DATA `rd` on the exact push cycle of the 5th byte. No OVR, count stays 4, FIFO order preserved.
- Reset mid-character: assert `reset_n` = 0 for 1 clock during DATA bit 4 of 0xFF.
  - No push, all outputs at reset values.
  - The following 0x12 is received correctly.
